sqrt_seq: RTL and testbench
===========================

Name: sqrt_seq

Overview:
- Parametrised, handshaked successor of the team's 8-bit iterative integer square root.
- Computes floor(sqrt(x)) and the remainder x - r^2 for an unsigned WIDTH-bit operand, one result bit per clock, MSB first.
- Adds a start/valid handshake, a busy indication and a remainder output.
- Sits as a multi-cycle arithmetic unit next to the datapath; the consumer launches an operand and waits for a one-cycle valid pulse.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and >= 2; an odd or smaller value is an elaboration error.
- HALF, WIDTH/2 (derived localparam, not overridable): result width and iteration count.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  launch request; sampled only in IDLE.
- x_i  input  WIDTH  unsigned operand; captured on the accepting edge.
- busy_o  output  1  high whenever state is not IDLE.
- valid_o  output  1  one-cycle pulse; result_o and rem_o are valid in that cycle.
- result_o  output  HALF  integer square root.
- rem_o  output  HALF+1  remainder x - floor(sqrt(x))^2. Maximum value is 2^(HALF+1)-2.

Behaviour:
- Reset (synchronous, rst_i high at a rising edge):
  - state=IDLE; busy_o=0; valid_o=0; result_o=0; rem_o=0; internal operand, partial root, remainder and counter all cleared.
  - rst_i dominates start_i.
  - Reset mid-computation aborts the operation; no valid_o is ever produced for it.
- States:
  - IDLE: if start_i=1, capture x_i, clear the partial root and accumulator, load bit counter = HALF-1, go to CALC.
  - CALC: one iteration per edge. Trial = partial root with the current bit set. If trial^2 <= captured x, keep the bit, else clear it. Decrement the counter. After the iteration with counter=0, go to DONE.
  - DONE: valid_o=1 for exactly this one cycle; result_o/rem_o show final values. Next edge goes to IDLE unconditionally.
- Trial-square arithmetic:
  - Incremental, no multiplier: acc + 2^(2b) + (root << (b+1)).
  - Evaluated in at least WIDTH+1 bits so the comparison cannot wrap.
- Latency: accept edge E0; iterations at E1..E_HALF; valid_o high in the cycle after E_HALF. WIDTH=8 gives 4 iteration edges then the pulse.
- Throughput: one operation per HALF+2 cycles; back-to-back starts are accepted on the IDLE cycle after DONE.
- start_i while busy_o=1 (CALC or DONE) is ignored. No queueing, no error flag.
- x_i changes after the accepting edge do not affect the result.
- Output hold: result_o/rem_o update only on entry to DONE and hold their values until the next DONE or reset. They must not show partial values during CALC.
- Boundaries:
  - x=0 gives result 0, rem 0.
  - x=2^WIDTH-1 gives result 2^HALF-1, rem 2^(HALF+1)-2.
  - Perfect squares give rem 0.

Optional Feature:
- Macro SQRT_ROUND_EN.
- Defined: result_o is rounded to nearest. Final root r is incremented when rem > r, which is equivalent to x >= r^2+r+1. An increment that would exceed 2^HALF-1 saturates at 2^HALF-1.
  - rem_o still reports x - floor(sqrt(x))^2.
  - Rounding is applied on the CALC->DONE edge, so latency is unchanged.
- Undefined: result_o is floor(sqrt(x)). No rounding logic is present.

Test Plan:
- WIDTH=8, start_i=1 with x_i=144 -> busy_o high for 5 cycles; valid_o pulses 5 cycles after acceptance (after 4 iteration edges); result_o=12, rem_o=0.
- WIDTH=8, x_i=0 then, in separate operations, x_i=255 -> results 0/0 and 15/30; outputs hold between pulses.
- WIDTH=8, accept x=200; pulse start_i with x_i=9 during CALC and during DONE -> ignored; single valid_o with result 14, rem 4. A start in the following IDLE cycle is accepted.
- WIDTH=8, accept x=100; assert rst_i on the 2nd CALC edge -> next cycle all outputs 0, state IDLE, no valid_o. A fresh start with x=50 gives 7/1.
- WIDTH=16, x=65535 -> result 255, rem 510, latency 8 iteration edges; x=40000 -> 200/0.
- SQRT_ROUND_EN defined, WIDTH=8:
  - x=110 -> 10 (rem 10)
  - x=111 -> 11 (rem 11)
  - x=240 -> 15 (rem 15)
  - x=255 -> 15 (saturated, rem 30)
  - Without the macro, x=111 -> 10.

Source files
------------

// File: rtl/sqrt_seq_if.sv
// sqrt_seq_if: operand/result handshake bundle for the sqrt_seq unit.
//   WIDTH     operand width (must match the sqrt_seq instance)
//   start_i   launch request (consumer -> unit)
//   x_i       unsigned operand, WIDTH bits (consumer -> unit)
//   busy_o    unit not idle (unit -> consumer)
//   valid_o   one-cycle result strobe (unit -> consumer)
//   result_o  square root, WIDTH/2 bits (unit -> consumer)
//   rem_o     remainder x - floor(sqrt(x))^2, WIDTH/2+1 bits (unit -> consumer)
// Modports: master = consumer side, slave = sqrt_seq side.
interface sqrt_seq_if #(
  parameter int WIDTH = 8
);
  localparam int HALF = WIDTH / 2;

  logic              start_i;
  logic [WIDTH-1:0]  x_i;
  logic              busy_o;
  logic              valid_o;
  logic [HALF-1:0]   result_o;
  logic [HALF:0]     rem_o;

  modport master (
    output start_i, x_i,
    input  busy_o, valid_o, result_o, rem_o
  );

  modport slave (
    input  start_i, x_i,
    output busy_o, valid_o, result_o, rem_o
  );
endinterface

// File: rtl/sqrt_seq.sv
// sqrt_seq: sequential unsigned integer square root, one result bit per clock,
// MSB first, with start/valid handshake, busy flag and remainder output.
//   WIDTH     operand width, even and >= 2 (HALF = WIDTH/2 result bits)
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   bus       sqrt_seq_if.slave: start_i, x_i, busy_o, valid_o, result_o, rem_o
// Latency: accept edge, HALF iteration edges, then a one-cycle valid_o pulse.
// Optional macro SQRT_ROUND_EN: result_o is rounded to nearest (saturating);
// rem_o always reports x - floor(sqrt(x))^2.
module sqrt_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  sqrt_seq_if.slave   bus
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  // One spare bit so the trial-square comparison can never wrap.
  localparam int SW   = WIDTH + 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
      $error("sqrt_seq: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [HALF-1:0]   root_q, root_d;
  logic [WIDTH-1:0]  acc_q, acc_d;      // always root_q squared
  logic [CW-1:0]     cnt_q, cnt_d;      // bit position under trial
  logic [HALF-1:0]   result_q, result_d;
  logic [HALF:0]     rem_q, rem_d;
  logic              busy, valid;

  logic [HALF-1:0]   bit_mask;
  logic [SW-1:0]     trial_sq;
  logic              keep;
  logic [HALF-1:0]   root_step;
  logic [WIDTH-1:0]  acc_step;
  logic [HALF:0]     rem_step;
  logic [HALF-1:0]   res_final;

  // (root | 2^b)^2 = root^2 + 2^(2b) + root*2^(b+1), since root has no bits at or below b.
  always_comb begin
    bit_mask  = HALF'(1) << cnt_q;
    trial_sq  = SW'(acc_q) + (SW'(1) << {cnt_q, 1'b0}) + ((SW'(root_q) << cnt_q) << 1);
    keep      = (trial_sq <= SW'(x_q));
    root_step = keep ? (root_q | bit_mask) : root_q;
    acc_step  = keep ? trial_sq[WIDTH-1:0] : acc_q;
    // True remainder is at most 2*root, so the low HALF+1 bits are exact.
    rem_step  = x_q[HALF:0] - acc_step[HALF:0];
`ifdef SQRT_ROUND_EN
    if ((rem_step > {1'b0, root_step}) && (root_step != '1)) begin
      res_final = root_step + 1'b1;
    end else begin
      res_final = root_step;
    end
`else
    res_final = root_step;
`endif
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    root_d   = root_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rem_d    = rem_q;
    busy     = 1'b1;
    valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start_i) begin
          x_d     = bus.x_i;
          root_d  = '0;
          acc_d   = '0;
          cnt_d   = CW'(HALF - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        root_d = root_step;
        acc_d  = acc_step;
        if (cnt_q == '0) begin
          result_d = res_final;
          rem_d    = rem_step;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q      <= '0;
      root_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rem_q    <= '0;
    end else begin
      x_q      <= x_d;
      root_q   <= root_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.busy_o   = busy;
  assign bus.valid_o  = valid;
  assign bus.result_o = result_q;
  assign bus.rem_o    = rem_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: self-checking bench for sqrt_seq at WIDTH=8 and WIDTH=16.
// Expected results come from a plain-arithmetic square-root model; rounding
// expectations follow SQRT_ROUND_EN when the build defines it.
module tb_sqrt_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sqrt_seq_if #(.WIDTH(8))  s8();
  sqrt_seq_if #(.WIDTH(16)) s16();

  sqrt_seq #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(s8));
  sqrt_seq #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(s16));

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned last_res [2];
  int unsigned last_rem [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int unsigned model_res(input int w, input int unsigned x);
    int unsigned r = isqrt(x);
`ifdef SQRT_ROUND_EN
    if ((x - r * r > r) && (r < (32'd1 << (w / 2)) - 1)) r = r + 1;
`endif
    return r;
  endfunction

  task automatic drive(input int w, input logic s, input logic [15:0] x);
    if (w == 8) begin
      s8.start_i = s;
      s8.x_i     = x[7:0];
    end else begin
      s16.start_i = s;
      s16.x_i     = x;
    end
  endtask

  // sel: 0 busy, 1 valid, 2 result, 3 rem
  function automatic logic [31:0] get(input int w, input int sel);
    if (w == 8) begin
      case (sel)
        0: return 32'(s8.busy_o);
        1: return 32'(s8.valid_o);
        2: return 32'(s8.result_o);
        default: return 32'(s8.rem_o);
      endcase
    end else begin
      case (sel)
        0: return 32'(s16.busy_o);
        1: return 32'(s16.valid_o);
        2: return 32'(s16.result_o);
        default: return 32'(s16.rem_o);
      endcase
    end
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the
  // IDLE cycle following the valid pulse. poke drives start_i with x_i=9
  // throughout CALC and DONE to show such starts are ignored.
  task automatic op(input int w, input int unsigned x, input bit poke);
    int idx = (w == 8) ? 0 : 1;
    int unsigned exp_res = model_res(w, x);
    int unsigned exp_rem = x - isqrt(x) * isqrt(x);
    drive(w, 1'b1, 16'(x));
    @(negedge clk);
    drive(w, poke, poke ? 16'd9 : 16'($urandom));
    for (int i = 1; i <= w / 2; i++) begin
      chk($sformatf("busy_calc w%0d x%0d c%0d", w, x, i), get(w, 0), 1);
      chk($sformatf("valid_calc w%0d x%0d c%0d", w, x, i), get(w, 1), 0);
      chk($sformatf("res_hold w%0d x%0d c%0d", w, x, i), get(w, 2), last_res[idx]);
      chk($sformatf("rem_hold w%0d x%0d c%0d", w, x, i), get(w, 3), last_rem[idx]);
      if (!poke) drive(w, 1'b0, 16'($urandom));
      @(negedge clk);
    end
    chk($sformatf("valid_done w%0d x%0d", w, x), get(w, 1), 1);
    chk($sformatf("busy_done w%0d x%0d", w, x), get(w, 0), 1);
    chk($sformatf("result w%0d x%0d", w, x), get(w, 2), exp_res);
    chk($sformatf("rem w%0d x%0d", w, x), get(w, 3), exp_rem);
    @(negedge clk);
    drive(w, 1'b0, 16'($urandom));
    chk($sformatf("valid_after w%0d x%0d", w, x), get(w, 1), 0);
    chk($sformatf("busy_after w%0d x%0d", w, x), get(w, 0), 0);
    chk($sformatf("res_after w%0d x%0d", w, x), get(w, 2), exp_res);
    last_res[idx] = exp_res;
    last_rem[idx] = exp_rem;
  endtask

  task automatic idle_hold(input int w, input int n);
    int idx = (w == 8) ? 0 : 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("idle_valid w%0d", w), get(w, 1), 0);
      chk($sformatf("idle_res w%0d", w), get(w, 2), last_res[idx]);
      chk($sformatf("idle_rem w%0d", w), get(w, 3), last_rem[idx]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(8, 1'b1, 16'd77);   // start held high under reset must be ignored
    drive(16, 1'b0, 16'd0);
    last_res = '{0, 0};
    last_rem = '{0, 0};
    @(negedge clk);
    @(negedge clk);
    for (int w = 8; w <= 16; w += 8) begin
      chk($sformatf("rst_busy w%0d", w), get(w, 0), 0);
      chk($sformatf("rst_valid w%0d", w), get(w, 1), 0);
      chk($sformatf("rst_result w%0d", w), get(w, 2), 0);
      chk($sformatf("rst_rem w%0d", w), get(w, 3), 0);
    end
    rst = 1'b0;
    drive(8, 1'b0, 16'd0);
    @(negedge clk);

    op(8, 144, 1'b0);
    op(8, 0, 1'b0);
    idle_hold(8, 3);
    op(8, 255, 1'b0);
    idle_hold(8, 2);
    op(8, 200, 1'b1);
    op(8, 9, 1'b0);           // back-to-back on the IDLE cycle after DONE

    // Reset on the second CALC edge aborts the operation.
    drive(8, 1'b1, 16'd100);
    @(negedge clk);
    drive(8, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", get(8, 0), 0);
    chk("abort_valid", get(8, 1), 0);
    chk("abort_result", get(8, 2), 0);
    chk("abort_rem", get(8, 3), 0);
    last_res = '{0, 0};
    last_rem = '{0, 0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", get(8, 1), 0);
    end
    op(8, 50, 1'b0);

    op(8, 110, 1'b0);
    op(8, 111, 1'b0);
    op(8, 240, 1'b0);
    op(8, 255, 1'b0);

    op(16, 65535, 1'b0);
    op(16, 40000, 1'b0);
    op(16, 0, 1'b0);

    for (int i = 0; i < 25; i++) op(8, $urandom_range(255, 0), 1'(i % 3 == 0));
    for (int i = 0; i < 12; i++) op(16, $urandom_range(65535, 0), 1'(i % 4 == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
